zircon_key_logic: RTL

Input-side counterpart of the LED output logic: samples eight push-button pins, synchronises and debounces them, and presents a stable key-level register plus sticky press-event flags and an interrupt to the bus-facing register block. It sits between the board key pins and the Avalon slave register file, mirroring how the LED logic sits between the register file and the LED pins.

---
 rtl/zircon_key_pkg.sv | 8 +
 rtl/zircon_key_debounce.sv | 55 +++++
 rtl/zircon_key_logic.sv | 62 ++++++
 3 files changed

// File: rtl/zircon_key_pkg.sv
// rtl/zircon_key_pkg.sv - shared constants for the key input logic
package zircon_key_pkg;

    localparam int          KEY_NUM          = 8;
    localparam logic [7:0]  KEY_RELEASED     = 8'hFF;
    localparam int          DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/zircon_key_debounce.sv
// rtl/zircon_key_debounce.sv - one-bit synchroniser, debounce counter, stable level and fall strobe
module zircon_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic csi_clk,
    input  logic rsi_reset_n,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronise the pin and accept a new level only after it has held steady long enough
    always_comb begin
        sync1_d  = pin_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; released level (1) after reset so a held key reads as a fresh press
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    // Strobe is taken from the next-state so pending can set on the same edge the level falls
    assign fall  = stable_q & ~stable_d;

endmodule

// File: rtl/zircon_key_logic.sv
// rtl/zircon_key_logic.sv - debounced key register with sticky press flags and IRQ (option: ZIRCON_KEY_IRQ_EN)
module zircon_key_logic
    import zircon_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic               csi_clk,
    input  logic               rsi_reset_n,
    input  logic [KEY_NUM-1:0] coe_key,
    input  logic [KEY_NUM-1:0] key_clear,
    input  logic [KEY_NUM-1:0] key_irq_mask,
    output logic [KEY_NUM-1:0] key_data,
    output logic [KEY_NUM-1:0] key_pending,
    output logic               key_irq
);

    logic [KEY_NUM-1:0] key_fall;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        zircon_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .csi_clk     (csi_clk),
            .rsi_reset_n (rsi_reset_n),
            .pin_in      (coe_key[i]),
            .level       (key_data[i]),
            .fall        (key_fall[i])
        );
    end

`ifdef ZIRCON_KEY_IRQ_EN
    logic [KEY_NUM-1:0] pending_q, pending_d;
    logic               irq_q, irq_d;

    // Press sets a flag, a clear strobe drops it; a coincident press wins so no event is lost
    always_comb begin
        pending_d = (pending_q & ~key_clear) | key_fall;
        irq_d     = |(pending_q & key_irq_mask);
    end

    // Pending flags and registered interrupt level
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign key_pending = pending_q;
    assign key_irq     = irq_q;
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{key_clear, key_irq_mask, key_fall};
    assign key_pending       = '0;
    assign key_irq           = 1'b0;
`endif

endmodule
